// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: shared flag indices, mantissa-width helper and S1 payload type
package fp_norm_pkg;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    function automatic int mant_w(input int mw);
        return mw + 4;
    endfunction

    // Width-independent part of the S1 payload; mantissa/exp/lz sit beside it
    typedef struct packed {
        logic sign;
        logic zero;
    } s1_ctl_t;
endpackage

// File: rtl/norm_lzc.sv
// norm_lzc: leading-zero counter over W bits with all-zero detect
module norm_lzc import fp_norm_pkg::*; #(
    parameter int W = 27
) (
    input  logic [W-1:0]             d,
    output logic [$clog2(W+1)-1:0]   cnt,
    output logic                     zero
);
    localparam int CW = $clog2(W+1);

    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++)
            if (d[i]) cnt = CW'(W - 1 - i);
    end

    assign zero = ~|d;
endmodule

// File: rtl/fp_norm_pack_pipe.sv
// fp_norm_pack_pipe: 2-stage normalise/round/pack with valid/ready handshake.
// Define FP_NORM_RNE_EN for round-to-nearest-even; otherwise the fraction is truncated.
module fp_norm_pack_pipe import fp_norm_pkg::*; #(
    parameter int EW = 8,
    parameter int MW = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [mant_w(MW)-1:0]  in_mant,
    input  logic [EW-1:0]          in_exp,
    input  logic                   in_co,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EW+MW:0]         out_word,
    output logic [2:0]             out_flags
);
    localparam int MI = mant_w(MW);
    localparam int LW = $clog2(MI + 1);
    localparam int XW = EW + 2;
    localparam logic [XW-1:0] EMAX = XW'((1 << EW) - 1);

    logic           v1, v2, s1_adv, s2_adv, zero_c;
    logic [MI-1:0]  m1, mn;
    logic [LW-1:0]  lz1, lz_c;
    logic [XW-1:0]  x1, e, ef;
    s1_ctl_t        c1;
    logic [MW-1:0]  frac;
    logic           cr, inx, unused_hid;
    logic [EW+MW:0] w_c;
    logic [2:0]     f_c;
`ifdef FP_NORM_RNE_EN
    logic           inc;
`endif

    norm_lzc #(.W(MI)) u_lzc (.d(in_mant), .cnt(lz_c), .zero(zero_c));

    assign s2_adv    = !v2 || out_ready;
    assign s1_adv    = s2_adv || !v1;
    assign in_ready  = s1_adv;
    assign out_valid = v2;

    // Carry case: shift right by one, folding the dropped bit into sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            m1  <= '0;
            lz1 <= '0;
            x1  <= '0;
            c1  <= '0;
        end else if (s1_adv) begin
            v1 <= in_valid;
            if (in_valid) begin
                m1  <= in_co ? {1'b1, in_mant[MI-1:2], |in_mant[1:0]} : in_mant;
                lz1 <= in_co ? '0 : lz_c;
                x1  <= XW'(in_exp) + XW'(in_co);
                c1  <= '{sign: in_sign, zero: !in_co && zero_c};
            end
        end
    end

    assign unused_hid = mn[MI-1];

    always_comb begin
        mn  = m1 << lz1;
        e   = x1 - XW'(lz1);
        inx = |mn[2:0];
`ifdef FP_NORM_RNE_EN
        inc = mn[2] & (mn[1] | mn[0] | mn[3]);
        {cr, frac} = {1'b0, mn[MW+2:3]} + (MW+1)'(inc);
`else
        cr   = 1'b0;
        frac = mn[MW+2:3];
`endif
        ef  = e + XW'(cr);
        w_c = {c1.sign, ef[EW-1:0], frac};
        f_c = '0;
        f_c[FLAG_INX] = inx;
        if (c1.zero) begin
            w_c = '0;
            f_c = '0;
        end else if (e[XW-1] || e == '0) begin
            w_c = {c1.sign, {(EW+MW){1'b0}}};
            f_c[FLAG_UNF] = 1'b1;
            f_c[FLAG_INX] = 1'b1;
        end else if (ef >= EMAX) begin
            w_c = {c1.sign, {EW{1'b1}}, {MW{1'b0}}};
            f_c[FLAG_OVF] = 1'b1;
            f_c[FLAG_INX] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2        <= 1'b0;
            out_word  <= '0;
            out_flags <= '0;
        end else if (s2_adv) begin
            v2 <= v1;
            if (v1) begin
                out_word  <= w_c;
                out_flags <= f_c;
            end
        end
    end
endmodule

// File: tb/tb_fp_norm_pack_pipe.sv
// tb_fp_norm_pack_pipe: directed + random checks against an arithmetic reference model
module tb_fp_norm_pack_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_sign = 1'b0, in_co = 1'b0, out_ready = 1'b0;
    logic [26:0] in_mant = '0;
    logic [7:0]  in_exp = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_word;
    logic [2:0]  out_flags;

    int checks = 0, errors = 0, cyc = 0;
    logic [34:0] q[$];
    int          qc[$];
    logic        held = 1'b0;
    logic [34:0] held_v = '0;

    fp_norm_pack_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_mant(in_mant), .in_exp(in_exp), .in_co(in_co),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    // Value = {co,mant} * 2^(exp-26); normalise by MSB position, round on the exact remainder
    function automatic logic [34:0] model(input logic s, input logic [26:0] mant,
                                          input logic [7:0] ex, input logic co);
        logic [27:0] m;
        int p, e, sh;
        longint sig, rem, half;
        logic inx, up;
        m = {co, mant};
        if (m == 0) return '0;
        p = 27;
        while (!m[p]) p--;
        e = int'(ex) + p - 26;
        if (p > 23) begin
            sh   = p - 23;
            sig  = longint'(m) >> sh;
            rem  = longint'(m) & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
        end else begin
            sig  = longint'(m) << (23 - p);
            rem  = 0;
            half = 1;
        end
        inx = (rem != 0);
        if (e <= 0) return {s, 31'd0, 3'b011};
`ifdef FP_NORM_RNE_EN
        up = (rem > half) || (rem == half && sig[0]);
`else
        up = 1'b0;
`endif
        sig = sig + longint'(up);
        if (sig == (longint'(1) << 24)) begin
            sig = longint'(1) << 23;
            e++;
        end
        if (e >= 255) return {s, 8'hff, 23'd0, 3'b101};
        return {s, e[7:0], sig[22:0], 2'b00, inx};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, check, then model both handshakes at the coming posedge
    task automatic step(input logic iv, input logic s, input logic [26:0] m, input logic [7:0] x,
                        input logic co, input logic ordy, input logic use_k,
                        input logic [34:0] k, output logic acc);
        in_valid = iv; in_sign = s; in_mant = m; in_exp = x; in_co = co; out_ready = ordy;
        #1;
        chk("in_ready", 64'(in_ready), 64'(ordy || q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0 && cyc - qc[0] >= 2));
        if (held) chk("hold", {out_valid, out_word, out_flags}, {1'b1, held_v});
        if (out_valid && ordy && q.size() > 0) begin
            chk("data", {out_word, out_flags}, q[0]);
            void'(q.pop_front());
            void'(qc.pop_front());
        end
        acc = iv && in_ready;
        if (acc) begin
            q.push_back(use_k ? k : model(s, m, x, co));
            qc.push_back(cyc);
        end
        held   = out_valid && !ordy;
        held_v = {out_word, out_flags};
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        logic a;
        step(1'b0, 1'b0, '0, '0, 1'b0, ordy, 1'b0, '0, a);
    endtask

    task automatic rnd(input logic ordy, output logic acc);
        step(1'b1, 1'($urandom), 27'($urandom) >> $urandom_range(0, 27), 8'($urandom),
             $urandom_range(0, 3) == 0, ordy, 1'b0, '0, acc);
    endtask

    initial begin
        logic a;
        logic [34:0] k_round;
        int sent;
`ifdef FP_NORM_RNE_EN
        k_round = {32'h40000000, 3'b001};
`else
        k_round = {32'h3FFFFFFF, 3'b001};
`endif
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_word", {out_word, out_flags}, 64'd0);
        rst_n = 1'b1;
        idle(1'b1);

        step(1'b1, 1'b0, 27'h0000000, 8'd127, 1'b1, 1'b1, 1'b1, {32'h40000000, 3'b000}, a);
        step(1'b1, 1'b0, 27'h0000008, 8'd127, 1'b0, 1'b1, 1'b1, {32'h34000000, 3'b000}, a);
        step(1'b1, 1'b0, 27'h7FFFFFC, 8'd127, 1'b0, 1'b1, 1'b1, k_round, a);
        step(1'b1, 1'b0, 27'h0000000, 8'd254, 1'b1, 1'b1, 1'b1, {32'h7F800000, 3'b101}, a);
        step(1'b1, 1'b0, 27'h0000008, 8'd10, 1'b0, 1'b1, 1'b1, {32'h00000000, 3'b011}, a);
        step(1'b1, 1'b1, 27'h0000000, 8'd77, 1'b0, 1'b1, 1'b1, {32'h00000000, 3'b000}, a);
        step(1'b1, 1'b1, 27'h0000000, 8'd255, 1'b0, 1'b1, 1'b1, {32'h00000000, 3'b000}, a);
        repeat (3) idle(1'b1);

        sent = 0;
        for (int c = 0; c < 20 && (sent < 4 || q.size() > 0); c++) begin
            if (sent < 4) begin
                rnd(!(c >= 1 && c <= 3), a);
                if (a) sent++;
            end else idle(!(c >= 1 && c <= 3));
        end
        chk("bp_sent", 64'(sent), 64'd4);
        chk("bp_drained", 64'(q.size()), 64'd0);

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 7) rnd($urandom_range(0, 9) < 7, a);
            else idle($urandom_range(0, 9) < 7);
        end
        for (int c = 0; c < 10 && q.size() > 0; c++) idle(1'b1);
        chk("rand_drained", 64'(q.size()), 64'd0);

        for (int c = 0; c < 6 && q.size() < 2; c++) rnd(1'b0, a);
        chk("full_before_rst", 64'(q.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_word", {out_word, out_flags}, 64'd0);
        q.delete();
        qc.delete();
        held = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle(1'b1);
        step(1'b1, 1'b0, 27'h0000000, 8'd127, 1'b1, 1'b1, 1'b1, {32'h40000000, 3'b000}, a);
        for (int c = 0; c < 10 && q.size() > 0; c++) idle(1'b1);
        chk("post_rst_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_norm_pack_pipe.md
# fp_norm_pack_pipe

Parametrised, pipelined normalise-round-pack stage for the FP adder datapath. Takes the raw sign/mantissa-sum/exponent/carry from the add/sub stage and returns a packed IEEE-style word. Adds what the combinational normaliser lacks: arbitrary exponent/fraction widths, a 2-stage valid/ready pipeline, round-to-nearest-even, and overflow/underflow/inexact flags.

## Interface
Parameters:
- EW, 8, exponent width
- MW, 23, stored fraction width (hidden bit not stored)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_sign  in  1  result sign
- in_mant  in  MW+4  [MW+3] hidden, [MW+2:3] fraction, [2] guard, [1] round, [0] sticky
- in_exp  in  EW  biased exponent of the unnormalised sum
- in_co  in  1  carry out of the mantissa adder (weight above hidden bit)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_word  out  1+EW+MW  {sign, exponent, fraction}
- out_flags  out  3  {overflow, underflow, inexact}

## Operation
- Stage 1 (register S1): if in_co, right-shift {co,mant} by 1, OR the shifted-out bit into sticky, exp+1. Otherwise compute lz = leading zeros of in_mant[MW+3:0] (norm_lzc); register mantissa, lz, zero flag, sign, exp.
- Stage 2 (register S2): left-shift mantissa by lz; e = exp − lz, computed in EW+2-bit signed arithmetic.
- Exact zero (in_co=0, in_mant=0): out_word = +0 (sign forced 0), flags 000.
- e ≤ 0: flush to zero, sign kept, underflow=1, inexact=1. No subnormals.
- Rounding (see Configuration). Inexact = guard|round|sticky after shift (with Co: including shifted-out bit).
- Round carry out of the hidden bit: fraction=0, e+1.
- Final e ≥ 2^EW−1: infinity (exp all ones, fraction 0), overflow=1, inexact=1.
- in_exp all ones is not special-cased; it produces overflow → infinity.
- Flags valid only with out_valid.

## Timing
- Latency 2 cycles from accepted input to out_valid; throughput 1 beat/cycle.
- Beat transfers when valid&&ready on that interface.
- S2 advances when !S2.valid || out_ready; S1 advances when S2 advances or !S1.valid; in_ready = !S1.valid || S1 advances (combinational from out_ready, no skid buffer).
- out_valid/out_word/out_flags held stable while out_valid && !out_ready.
- Reset: all valid bits 0, in_ready=1 after reset, out_word=0, out_flags=0. Reset mid-operation discards in-flight beats; no output on the first cycle after deassertion.
- Ordering strictly preserved; no beat dropped or duplicated.

## Configuration
- FP_NORM_RNE_EN defined: round-to-nearest-even — increment if G && (R|S|LSB).
- Undefined: truncation (never increment); inexact and overflow/underflow detection unchanged; rounding logic removed.

## Structure
- Package fp_norm_pkg: flag bit indices (FLAG_OVF=2, FLAG_UNF=1, FLAG_INX=0), function for mantissa-in width (MW+4), typedef for the S1 pipeline payload.
- Sub-module norm_lzc: parametrised leading-zero counter over MW+4 bits, outputs count and all-zero.

## Test plan (EW=8, MW=23)
- Carry: in_co=1, in_mant=0x0000000, exp=127 → out_word 0x40000000, flags 000 (1.0+1.0).
- Cancellation: in_co=0, in_mant=0x0000008, exp=127 → 0x34000000, flags 000.
- Round-up: in_mant=0x7FFFFFC, exp=127 → with FP_NORM_RNE_EN 0x40000000, flags 001; without 0x3FFFFFFF, flags 001.
- Overflow/underflow: in_co=1, exp=254 → 0x7F800000, flags 101; in_mant=0x0000008, exp=10 → 0x00000000, flags 011.
- Backpressure: 4 back-to-back beats, out_ready low cycles 2–4 → in_ready low while both stages full, outputs held stable, all 4 delivered in order.
- Reset: assert rst_n low with both stages full → out_valid 0 immediately, no stale beat after release, in_ready=1.
